// File: rtl/mem_arbiter_pkg.sv
// Shared processor package: arbiter FSM states, grant encoding and the
// fairness rule used when fetch and memory stage request together.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam int unsigned CNT_W = 4;

    // A tie goes to whichever requester was not served last.
    function automatic grant_t pick_grant(input logic i_pend, input logic d_pend,
                                          input grant_t last);
        if (i_pend && d_pend) begin
            if (last == GRANT_D) return GRANT_I;
            return GRANT_D;
        end
        if (d_pend) return GRANT_D;
        return GRANT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter with zero flag; times the BUSY phase of an access.
module lat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and memory-stage accesses onto one single-port memory
// and raises the pipeline stall requests while an access is outstanding.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    input  logic          halt,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          err
);

    arb_state_t       state, state_next;
    grant_t           last_grant, grant_sel;
    logic             grant_fire;
    logic             i_pend, d_pend;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             wr_q;
    logic [CNT_W-1:0] count;
    logic             cnt_zero;
    logic             final_busy;

    assign i_pend     = if_req & ~halt;
    assign d_pend     = d_rd | d_wr;
    assign grant_sel  = pick_grant(i_pend, d_pend, last_grant);
    assign final_busy = (state == ST_BUSY) && cnt_zero;

    lat_counter #(.W(CNT_W)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_fire),
        .load_val (CNT_W'(LATENCY - 1)),
        .dec      (state == ST_BUSY),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_next = state;
        grant_fire = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        if_done    = 1'b0;
        d_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_pend || d_pend) begin
                    state_next = ST_BUSY;
                    grant_fire = 1'b1;
                end
            end
            ST_BUSY: begin
                mem_en = 1'b1;
                mem_wr = wr_q;
                if (cnt_zero) state_next = ST_DONE;
            end
            ST_DONE: begin
                if_done    = (last_grant == GRANT_I);
                d_done     = (last_grant == GRANT_D);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // last_grant doubles as the owner of the access in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            err        <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_next;
            if (grant_fire) begin
                last_grant <= grant_sel;
                if (grant_sel == GRANT_D) begin
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    wr_q    <= d_wr;
                    if (d_rd && d_wr) err <= 1'b1;
                end else begin
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                    wr_q    <= 1'b0;
                end
            end
            if (final_busy) begin
                if (last_grant == GRANT_I) begin
                    if_rdata <= mem_rdata;
                end else if (!wr_q) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_pend & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a timeline model.
module tb_mem_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_rd, d_wr, halt;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_done, d_done, mem_en, mem_wr, stall_if, stall_mem, err;

    logic        use_fixed;
    logic [15:0] fixed_rdata;

    int checks = 0;
    int errors = 0;

    // Model: an access granted at cycle g is BUSY in g+1..g+L, DONE at g+L+1.
    int          t;
    int          g;
    bit          m_owner_d, m_last_d, m_wr, m_err;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] exp_if_rdata, exp_d_rdata;
    bit          exp_mem_en, exp_mem_wr, exp_if_done, exp_d_done;
    bit          prev_i_done, prev_d_done;

    always #5 clk = ~clk;

    function automatic logic [15:0] scramble(input logic [15:0] a);
        return {a[7:0] ^ 8'hA5, a[15:8] + 8'h3C};
    endfunction

    assign mem_rdata = use_fixed ? fixed_rdata : scramble(mem_addr);

    mem_arbiter #(.LATENCY(L), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .halt(halt),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        g = -1; m_last_d = 1'b1; m_err = 1'b0; m_wr = 1'b0;
        exp_if_rdata = '0; exp_d_rdata = '0;
    endtask

    task automatic begin_cycle();
        bit in_busy, in_done;
        #1;
        in_busy     = (g >= 0) && (t >= g + 1) && (t <= g + L);
        in_done     = (g >= 0) && (t == g + L + 1);
        exp_mem_en  = in_busy;
        exp_mem_wr  = in_busy && m_wr;
        exp_if_done = in_done && !m_owner_d;
        exp_d_done  = in_done && m_owner_d;
        if (exp_if_done) exp_if_rdata = use_fixed ? fixed_rdata : scramble(m_addr);
        if (exp_d_done && !m_wr) exp_d_rdata = use_fixed ? fixed_rdata : scramble(m_addr);
        chk("mem_en", mem_en, exp_mem_en);
        chk("mem_wr", mem_wr, exp_mem_wr);
        chk("if_done", if_done, exp_if_done);
        chk("d_done", d_done, exp_d_done);
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        chk("err", err, m_err);
        chk("stall_if", stall_if, if_req && !exp_if_done);
        chk("stall_mem", stall_mem, (d_rd || d_wr) && !exp_d_done);
        if (exp_mem_en) chk("mem_addr", mem_addr, m_addr);
        if (exp_mem_wr) chk("mem_wdata", mem_wdata, m_wdata);
    endtask

    task automatic end_cycle();
        bit i_p, d_p;
        prev_i_done = exp_if_done;
        prev_d_done = exp_d_done;
        i_p = if_req && !halt;
        d_p = d_rd || d_wr;
        if (!rst) begin
            model_reset();
        end else if (((g < 0) || (t >= g + L + 2)) && (i_p || d_p)) begin
            m_owner_d = (i_p && d_p) ? !m_last_d : d_p;
            m_last_d  = m_owner_d;
            m_addr    = m_owner_d ? d_addr : if_addr;
            m_wdata   = d_wdata;
            m_wr      = m_owner_d && d_wr;
            if (m_owner_d && d_rd && d_wr) m_err = 1'b1;
            g = t;
        end
        @(negedge clk);
        t++;
        if (prev_i_done) if_req = 1'b0;
        if (prev_d_done) begin d_rd = 1'b0; d_wr = 1'b0; end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic do_reset();
        if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; halt = 1'b0; rst = 1'b0;
        cyc(1);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; halt = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        use_fixed = 1'b1; fixed_rdata = 16'hABCD;
        t = 0; m_owner_d = 1'b0; m_addr = '0; m_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        begin_cycle();
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        end_cycle();
        rst = 1'b1;

        // fetch only
        if_req = 1'b1; if_addr = 16'h0010;
        begin_cycle(); chk("fetch_stall_c0", stall_if, 1'b1); end_cycle();
        for (int c = 1; c <= 2; c++) begin
            begin_cycle();
            chk("fetch_en_c12", mem_en, 1'b1);
            chk("fetch_addr", mem_addr, 16'h0010);
            chk("fetch_stall_c12", stall_if, 1'b1);
            end_cycle();
        end
        begin_cycle();
        chk("fetch_done_c3", if_done, 1'b1);
        chk("fetch_rdata_c3", if_rdata, 16'hABCD);
        end_cycle();
        cyc(2);
        use_fixed = 1'b0;

        // tie after reset: I first, then D
        do_reset();
        if_req = 1'b1; if_addr = 16'h0100; d_rd = 1'b1; d_addr = 16'h0200;
        cyc(3);
        begin_cycle(); chk("tie_i_done_c3", if_done, 1'b1); chk("tie_d_wait_c3", d_done, 1'b0); end_cycle();
        cyc(3);
        begin_cycle(); chk("tie_d_done_c7", d_done, 1'b1); chk("tie_d_rdata", d_rdata, scramble(16'h0200)); end_cycle();
        cyc(2);

        // store
        d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        cyc(1);
        for (int c = 1; c <= L; c++) begin
            begin_cycle();
            chk("store_wr", mem_wr, 1'b1);
            chk("store_addr", mem_addr, 16'h0020);
            chk("store_data", mem_wdata, 16'h1234);
            end_cycle();
        end
        begin_cycle(); chk("store_done", d_done, 1'b1); chk("store_rdata_kept", d_rdata, scramble(16'h0200)); end_cycle();
        cyc(2);

        // halt blocks fetch, data still served
        halt = 1'b1; if_req = 1'b1; if_addr = 16'h0300;
        for (int c = 0; c < 4; c++) begin
            begin_cycle(); chk("halt_no_en", mem_en, 1'b0); chk("halt_stall", stall_if, 1'b1); end_cycle();
        end
        d_rd = 1'b1; d_addr = 16'h0400;
        cyc(3);
        begin_cycle(); chk("halt_d_done", d_done, 1'b1); chk("halt_stall2", stall_if, 1'b1); end_cycle();
        halt = 1'b0;
        cyc(6);

        // illegal read+write
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0500; d_wdata = 16'h5A5A;
        cyc(1);
        begin_cycle(); chk("illegal_wr", mem_wr, 1'b1); end_cycle();
        cyc(1);
        begin_cycle(); chk("illegal_done", d_done, 1'b1); chk("illegal_err", err, 1'b1); end_cycle();
        cyc(3);
        begin_cycle(); chk("illegal_err_sticky", err, 1'b1); end_cycle();

        // reset in the second BUSY cycle
        d_rd = 1'b1; d_addr = 16'h0600;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1; d_rd = 1'b0;
        begin_cycle();
        chk("abort_en", mem_en, 1'b0);
        chk("abort_err", err, 1'b0);
        chk("abort_done", d_done, 1'b0);
        end_cycle();
        cyc(3);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!if_req && $urandom_range(2) == 0) begin
                if_req = 1'b1; if_addr = 16'($urandom);
            end else if (if_req && $urandom_range(31) == 0) begin
                if_req = 1'b0;
            end
            if (!(d_rd || d_wr) && $urandom_range(2) == 0) begin
                int k;
                k = int'($urandom_range(9));
                d_rd = (k < 5) || (k == 9);
                d_wr = (k >= 5);
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            if ($urandom_range(7) == 0) halt = ~halt;
            rst = ($urandom_range(63) != 0);
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: number of BUSY cycles per memory access; legal range 1..15.
REQ-002 Parameter AW, default 16: address width.
REQ-003 Parameter DW, default 16: data width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 if_req  in  1  fetch read request; held high until if_done.
REQ-007 if_addr  in  AW  fetch address.
REQ-008 if_rdata  out  DW  fetch read data; valid while if_done=1.
REQ-009 if_done  out  1  one-cycle fetch completion pulse.
REQ-010 d_rd, d_wr  in  1 each  memory-stage read and write requests; held high until d_done.
REQ-011 d_addr, d_wdata  in  AW, DW  memory-stage address and write data.
REQ-012 d_rdata  out  DW  memory-stage read data; valid while d_done=1.
REQ-013 d_done  out  1  one-cycle memory-stage completion pulse.
REQ-014 halt  in  1  processor halted; blocks new fetch grants.
REQ-015 mem_en, mem_wr  out  1 each  single-port memory enable and write strobe.
REQ-016 mem_addr, mem_wdata  out  AW, DW  memory address and write data.
REQ-017 mem_rdata  in  DW  memory read data.
REQ-018 stall_if, stall_mem  out  1 each  pipeline stall requests for fetch and for the memory stage.
REQ-019 err  out  1  sticky flag: d_rd and d_wr were both high at a grant.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-021 IDLE SHALL grant on a request at the clock edge and move to BUSY, latching the requester, address, wdata and write flag.
REQ-022 Grant priority: only a data request pending -> D; only a fetch request pending with halt=0 -> I; both pending -> the requester not granted last (last_grant toggles fairness).
REQ-023 A fetch request with halt=1 SHALL NOT be granted; a data request SHALL still be granted.
REQ-024 BUSY SHALL last exactly LATENCY cycles, counted by a down-counter loaded with LATENCY-1.
REQ-025 Throughout BUSY, the memory outputs SHALL be driven from the latched values: mem_en=1, mem_wr=latched write flag, mem_addr and mem_wdata latched.
REQ-026 Outside BUSY, mem_en and mem_wr SHALL be 0.
REQ-027 On the final BUSY edge, the arbiter SHALL register mem_rdata into the granted requester's rdata and move to DONE.
REQ-028 DONE SHALL last one cycle: the granted requester's done=1, no grant is made, and the next state is IDLE.
REQ-029 Latency: a request raised in IDLE SHALL see done exactly LATENCY+1 cycles later (LATENCY=2: req in cycle 0, done in cycle 3).
REQ-030 The rdata outputs SHALL hold their last value until the next completion for the same requester.
REQ-031 A write SHALL complete with d_done and leave d_rdata unchanged.
REQ-032 d_rd=d_wr=1 at a grant SHALL be treated as a write and SHALL set err.
REQ-033 stall_if SHALL equal if_req & ~if_done.
REQ-034 stall_mem SHALL equal (d_rd|d_wr) & ~d_done.
REQ-035 Both stall outputs SHALL be combinational from inputs and registered state.
REQ-036 Requests that drop during BUSY SHALL NOT abort the access; the access SHALL complete and done SHALL still pulse.

Reset
REQ-037 With rst=0 at an edge, the arbiter SHALL take state IDLE, counter 0, last_grant=D (so the first tie goes to I), err=0, if_rdata=d_rdata=0, done outputs 0 and memory outputs 0.
REQ-038 A reset during BUSY or DONE SHALL abort the access with no done pulse; mem_en SHALL be 0 in the cycle after the reset edge.

Structure
REQ-039 The state encoding (IDLE/BUSY/DONE) and the grant encoding (I/D) SHALL live in the shared processor package.
REQ-040 A sub-module lat_counter (loadable down-counter with a zero flag) SHALL be used.
REQ-041 The arbiter SHALL sit between fetch, the memory stage and a single-port memory, and SHALL drive the pipeline stall/enable logic.

Verification
REQ-042 Fetch only: LATENCY=2, if_req=1, if_addr=0x0010, mem_rdata=0xABCD -> mem_en high cycles 1-2; if_done=1 and if_rdata=0xABCD in cycle 3; stall_if=1 in cycles 0-2.
REQ-043 Tie after reset: if_req and d_rd both raised in cycle 0 -> I served first (done cycle 3), then D granted cycle 4 (d_done cycle 7).
REQ-044 Store: d_wr=1, d_addr=0x0020, d_wdata=0x1234 -> mem_wr=1 with addr 0x0020 and data 0x1234 for LATENCY cycles; d_done pulses once; d_rdata unchanged.
REQ-045 Halt: halt=1 with if_req=1 -> no mem_en and stall_if stays 1; a d_rd raised meanwhile is still served.
REQ-046 Mid-access reset: rst=0 in the second BUSY cycle -> no done pulse; mem_en=0 and err=0 the next cycle.
REQ-047 Illegal request: d_rd=d_wr=1 -> write performed and err=1, which stays set until reset.
